prng_scheduler: RTL and testbench
=================================

PRNG_SCHEDULER -- requirements
Module: prng_scheduler

Interface
REQ-001 Parameter: WIDTH, 16, LFSR and output word width; fixed at 16 because the tap set below is defined only for 16 bits.
REQ-002 Parameter: NREQ, 4, number of requesters, 2..8.
REQ-003 Parameter: STEPS, 4, number of LFSR advances between deliveries, 1..15.
REQ-004 Parameter: SEED, 16'hACE1, reset seed and substitute for any all-zero seed.
REQ-005 Port: clock, input, 1, clock; all state updates on its rising edge.
REQ-006 Port: reset, input, 1, synchronous, active-high.
REQ-007 Port: seed_load, input, 1, level request to reload the LFSR from seed.
REQ-008 Port: seed, input, WIDTH, seed value.
REQ-009 Port: req, input, NREQ, one request line per requester.
REQ-010 Port: grant, output, NREQ, one-hot, identifies the requester receiving rnd.
REQ-011 Port: rnd, output, WIDTH, delivered random word.
REQ-012 Port: rnd_valid, output, 1, one-cycle strobe qualifying grant and rnd.
REQ-013 Port: busy, output, 1, high whenever the FSM state is not IDLE.

Function
REQ-014 The LFSR SHALL be Fibonacci, polynomial x^16+x^14+x^13+x^11+1; each advance SHALL compute next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
REQ-015 The FSM SHALL have exactly four states: IDLE, SEED, GEN and DELIVER.
REQ-016 In IDLE, if seed_load=1, the FSM SHALL go to SEED; seed_load SHALL take priority over req.
REQ-017 SEED SHALL last 1 cycle, SHALL load lfsr with seed (or with SEED if seed==0), and SHALL return to IDLE.
REQ-018 In IDLE with seed_load=0 and req!=0, the FSM SHALL latch the arbitration winner index and go to GEN.
REQ-019 GEN SHALL last exactly STEPS cycles and SHALL advance the LFSR once per cycle; the LFSR SHALL NOT advance in any other state.
REQ-020 DELIVER SHALL last 1 cycle, SHALL drive rnd_valid=1 with grant one-hot at the latched winner, and SHALL then return to IDLE.
REQ-021 rnd SHALL register the LFSR value on entry to DELIVER and SHALL hold that value until the next delivery.
REQ-022 Latency: with req sampled in IDLE at cycle 0, rnd_valid SHALL be high in cycle STEPS+1.
REQ-023 Throughput: back-to-back deliveries SHALL be spaced STEPS+2 cycles apart.
REQ-024 grant SHALL be 0 in every cycle where rnd_valid=0.
REQ-025 req changes during GEN or DELIVER SHALL be ignored; a latched request SHALL always complete, even if its req line drops.
REQ-026 seed_load asserted outside IDLE SHALL be ignored; because seed_load is a level, a request still held when the FSM returns to IDLE SHALL be honoured.
REQ-027 The LFSR SHALL never hold 0.

Reset
REQ-028 On reset, the FSM SHALL go to IDLE and the LFSR SHALL load SEED.
REQ-029 On reset, grant, rnd, rnd_valid and busy SHALL all be 0.
REQ-030 On reset, the round-robin pointer SHALL be set to NREQ-1, so requester 0 has first priority.
REQ-031 Reset asserted in any state, including mid-GEN, SHALL abort the operation with no rnd_valid pulse.

Configuration
REQ-032 Macro PRNG_SCHED_RR_EN selects the arbitration policy.
REQ-033 When PRNG_SCHED_RR_EN is defined, arbitration SHALL be round-robin: the search SHALL start at (last winner + 1) mod NREQ, and the pointer SHALL update on each entry to GEN.
REQ-034 When PRNG_SCHED_RR_EN is not defined, arbitration SHALL be fixed priority with the lowest index winning, and no pointer register SHALL exist.

Verification
REQ-035 Scenario: reset, then req=4'b0001 -> grant=4'b0001, rnd_valid=1 in cycle 5, rnd=16'hCE1E (intermediate LFSR values 59C3, B387, 670F).
REQ-036 Scenario: seed_load=1 with seed=16'h0000 while idle -> LFSR holds 16'hACE1; the following request yields rnd=16'hCE1E.
REQ-037 Scenario: req=4'b1111 held, RR enabled -> grant sequence 0001, 0010, 0100, 1000, 0001, with pulses 6 cycles apart.
REQ-038 Scenario: req=4'b1111 held, RR disabled -> grant=4'b0001 on every delivery; consecutive rnd values 16'hCE1E then the LFSR advanced 4 further steps.
REQ-039 Scenario: seed_load and req asserted together in IDLE -> SEED is taken first, then GEN next cycle; delivery uses the new seed.
REQ-040 Scenario: reset asserted in the 2nd GEN cycle -> no rnd_valid, busy=0 next cycle, LFSR=16'hACE1, rnd=0.

Source files
------------

// File: rtl/prng_scheduler.sv
// Arbitrated PRNG: winners of req each get a 16-bit LFSR word after STEPS advances.
// Define PRNG_SCHED_RR_EN for round-robin arbitration (default: fixed lowest-index priority).
module prng_scheduler #(
  parameter int unsigned     WIDTH = 16,
  parameter int unsigned     NREQ  = 4,
  parameter int unsigned     STEPS = 4,
  parameter logic [WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic [WIDTH-1:0] rnd,
  output logic             rnd_valid,
  output logic             busy
);

  localparam int unsigned IdxW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  LastStep = 4'(STEPS - 1);

  typedef enum logic [1:0] {StIdle, StSeed, StGen, StDeliver} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic [3:0]       step_q, step_d;
  logic [IdxW-1:0]  win_q, win_d;
  logic [IdxW-1:0]  arb_idx;
  logic             arb_found;
  logic [WIDTH-1:0] lfsr_adv;
  logic [WIDTH-1:0] seed_eff;

  assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // An all-zero seed would lock the LFSR, so substitute the default.
  assign seed_eff = (seed == '0) ? SEED : seed;

`ifdef PRNG_SCHED_RR_EN
  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr_q) + 1 + k) % NREQ;
      if (!arb_found && req[IdxW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'(cand);
      end
    end
  end
`else
  always_comb begin
    arb_found = |req;
    arb_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) arb_idx = IdxW'(k);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    rnd_d   = rnd_q;
    step_d  = step_q;
    win_d   = win_q;
`ifdef PRNG_SCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (seed_load) begin
          state_d = StSeed;
        end else if (arb_found) begin
          state_d = StGen;
          win_d   = arb_idx;
          step_d  = '0;
`ifdef PRNG_SCHED_RR_EN
          ptr_d   = arb_idx;
`endif
        end
      end
      StSeed: begin
        lfsr_d  = seed_eff;
        state_d = StIdle;
      end
      StGen: begin
        lfsr_d = lfsr_adv;
        if (step_q == LastStep) begin
          state_d = StDeliver;
          rnd_d   = lfsr_adv;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      StDeliver: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      rnd_q   <= '0;
      step_q  <= '0;
      win_q   <= '0;
`ifdef PRNG_SCHED_RR_EN
      ptr_q   <= IdxW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rnd_q   <= rnd_d;
      step_q  <= step_d;
      win_q   <= win_d;
`ifdef PRNG_SCHED_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign rnd_valid = (state_q == StDeliver);
  assign rnd       = rnd_q;

  always_comb begin
    grant = '0;
    if (rnd_valid) grant[win_q] = 1'b1;
  end

endmodule

// File: tb/tb_prng_scheduler.sv
// Directed bench for prng_scheduler with hand-computed LFSR words and grant patterns.
module tb_prng_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic [3:0]  req = '0;
  logic [3:0]  grant;
  logic [15:0] rnd;
  logic        rnd_valid;
  logic        busy;

  int total = 0;
  int bad = 0;
  int stray_grants = 0;
  int n;

  logic [15:0] c_rnd [3];
  logic [3:0]  c_grant [5];

  always #5 clock = ~clock;

  prng_scheduler #(
    .WIDTH(16),
    .NREQ (4),
    .STEPS(4),
    .SEED (16'hACE1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .seed_load(seed_load),
    .seed     (seed),
    .req      (req),
    .grant    (grant),
    .rnd      (rnd),
    .rnd_valid(rnd_valid),
    .busy     (busy)
  );

  always @(negedge clock) begin
    if (!reset && !rnd_valid && grant != 4'b0000) stray_grants++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!rnd_valid && cnt < 20);
  endtask

  initial begin
    c_rnd[0] = 16'hCE1E;
    c_rnd[1] = 16'hE1E4;
    c_rnd[2] = 16'h1E45;
`ifdef PRNG_SCHED_RR_EN
    c_grant[0] = 4'b0001;
    c_grant[1] = 4'b0010;
    c_grant[2] = 4'b0100;
    c_grant[3] = 4'b1000;
    c_grant[4] = 4'b0001;
`else
    for (int i = 0; i < 5; i++) c_grant[i] = 4'b0001;
`endif

    tick();
    tick();
    chk("rst_grant", {12'h0, grant}, 16'h0000);
    chk("rst_rnd", rnd, 16'h0000);
    chk("rst_valid", {15'h0, rnd_valid}, 16'h0000);
    chk("rst_busy", {15'h0, busy}, 16'h0000);
    reset = 1'b0;

    // Single request, dropped after latching; delivery at cycle 5.
    req = 4'b0001;
    tick();
    chk("a_busy_gen", {15'h0, busy}, 16'h0001);
    chk("a_no_valid1", {15'h0, rnd_valid}, 16'h0000);
    req = 4'b0000;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("a_no_valid", {15'h0, rnd_valid}, 16'h0000);
    end
    tick();
    chk("a_valid", {15'h0, rnd_valid}, 16'h0001);
    chk("a_grant", {12'h0, grant}, 16'h0001);
    chk("a_rnd", rnd, 16'hCE1E);
    tick();
    chk("a_idle_busy", {15'h0, busy}, 16'h0000);
    chk("a_valid_low", {15'h0, rnd_valid}, 16'h0000);
    chk("a_grant_low", {12'h0, grant}, 16'h0000);
    chk("a_rnd_hold", rnd, 16'hCE1E);

    // Zero seed reloads the default seed.
    seed = 16'h0000;
    seed_load = 1'b1;
    tick();
    chk("b_seed_busy", {15'h0, busy}, 16'h0001);
    seed_load = 1'b0;
    tick();
    chk("b_idle", {15'h0, busy}, 16'h0000);
    req = 4'b0001;
    wait_valid(n);
    req = 4'b0000;
    chk("b_latency", 16'(n), 16'd5);
    chk("b_rnd", rnd, 16'hCE1E);
    tick();

    // All requesters held: back-to-back deliveries.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    wait_valid(n);
    chk("c_latency", 16'(n), 16'd5);
    chk("c_grant0", {12'h0, grant}, {12'h0, c_grant[0]});
    chk("c_rnd0", rnd, c_rnd[0]);
    for (int k = 1; k < 5; k++) begin
      wait_valid(n);
      chk("c_gap", 16'(n), 16'd6);
      chk("c_grant", {12'h0, grant}, {12'h0, c_grant[k]});
      if (k < 3) chk("c_rnd", rnd, c_rnd[k]);
    end
    req = 4'b0000;
    tick();

    // seed_load and req together: seed first, then generation from the new seed.
    seed = 16'h0001;
    seed_load = 1'b1;
    req = 4'b0010;
    tick();
    chk("d_seed_busy", {15'h0, busy}, 16'h0001);
    chk("d_seed_novalid", {15'h0, rnd_valid}, 16'h0000);
    seed_load = 1'b0;
    wait_valid(n);
    req = 4'b0000;
    chk("d_latency", 16'(n), 16'd6);
    chk("d_grant", {12'h0, grant}, 16'h0002);
    chk("d_rnd", rnd, 16'h0010);

    // seed_load during GEN is ignored, then honoured once back in IDLE.
    tick();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    seed = 16'h0000;
    seed_load = 1'b1;
    wait_valid(n);
    chk("e_latency", 16'(n), 16'd4);
    chk("e_rnd", rnd, 16'h0100);
    tick();
    chk("e_idle", {15'h0, busy}, 16'h0000);
    tick();
    chk("e_seed_taken", {15'h0, busy}, 16'h0001);
    seed_load = 1'b0;
    tick();
    req = 4'b0001;
    wait_valid(n);
    req = 4'b0000;
    chk("e_latency2", 16'(n), 16'd5);
    chk("e_rnd2", rnd, 16'hCE1E);
    tick();

    // Reset during the second GEN cycle aborts the delivery.
    req = 4'b0001;
    tick();
    tick();
    reset = 1'b1;
    req = 4'b0000;
    tick();
    chk("f_busy", {15'h0, busy}, 16'h0000);
    chk("f_valid", {15'h0, rnd_valid}, 16'h0000);
    chk("f_rnd", rnd, 16'h0000);
    chk("f_grant", {12'h0, grant}, 16'h0000);
    reset = 1'b0;
    req = 4'b0001;
    wait_valid(n);
    req = 4'b0000;
    chk("f_latency", 16'(n), 16'd5);
    chk("f_rnd_after", rnd, 16'hCE1E);
    tick();

    chk("stray_grants", 16'(stray_grants), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
